// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler: owns a pool of enemy bullets. Spawns them under the
// enemy plane on a frame cooldown and advances live bullets once per frame.
// Bullets retire when they leave the screen or hit the player. Firing freezes
// once the player has taken MAX_HITS hits.
// Optional feature macro: ENEMY_AIMED_FIRE_EN adds the my_plane_x input and a
// per-slot horizontal drift toward the player, latched when the bullet spawns.
module enemy_fire_scheduler #(
  parameter int unsigned NUM_SLOTS     = 4,
  parameter int unsigned FIRE_PERIOD   = 30,
  parameter int unsigned BULLET_SPEED  = 6,
  parameter int unsigned SCREEN_H      = 768,
  parameter int unsigned PLANE_HALF_H  = 64,
  parameter int unsigned BULLET_HALF_H = 16,
  parameter int unsigned MAX_HITS      = 3,
  localparam int unsigned SW           = $clog2(NUM_SLOTS),
  localparam int unsigned CW           = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vs_neg,
  input  logic                     play,
  input  logic [CW-1:0]            enemy_x,
  input  logic [CW-1:0]            enemy_y,
`ifdef ENEMY_AIMED_FIRE_EN
  input  logic [CW-1:0]            my_plane_x,
`endif
  input  logic                     hit_valid,
  input  logic [SW-1:0]            hit_slot,
  output logic [NUM_SLOTS-1:0]     slot_active,
  output logic [CW*NUM_SLOTS-1:0]  bullet_x,
  output logic [CW*NUM_SLOTS-1:0]  bullet_y,
  output logic [3:0]               hits,
  output logic                     frozen,
  output logic                     busy,
  output logic                     overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_FIRE = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [SW-1:0]                 idx_q, idx_d;
  logic [7:0]                    cool_q, cool_d;
  logic [NUM_SLOTS-1:0]          act_q, act_d;
  logic [NUM_SLOTS-1:0][CW-1:0]  x_q, x_d;
  logic [NUM_SLOTS-1:0][CW-1:0]  y_q, y_d;
  logic [3:0]                    hits_q, hits_d;
  logic                          frozen_q, frozen_d;
  logic                          busy_q, busy_d;
  logic                          overrun_q, overrun_d;

  logic [NUM_SLOTS-1:0]          hit_vec;
  logic [11:0]                   y_new;
  logic                          spawned;

`ifdef ENEMY_AIMED_FIRE_EN
  // dir encoding: 2'b01 = +1, 2'b11 = -1, 2'b00 = straight down
  logic [NUM_SLOTS-1:0][1:0]     dir_q, dir_d;
  logic signed [12:0]            x_new;
  logic signed [12:0]            aim_diff;
`endif

  // One-hot view of an accepted hit; only live slots while playing and not frozen
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_vec[i] = hit_valid && play && !frozen_q && act_q[i] && (hit_slot == SW'(i));
    end
  end

  // Next-state: hits are applied first so MOVE and FIRE see the cleared slot
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cool_d    = cool_q;
    act_d     = act_q & ~hit_vec;
    x_d       = x_q;
    y_d       = y_q;
    hits_d    = hits_q;
    overrun_d = 1'b0;
    y_new     = '0;
    spawned   = 1'b0;
`ifdef ENEMY_AIMED_FIRE_EN
    dir_d     = dir_q;
    x_new     = '0;
    aim_diff  = '0;
`endif

    if (|hit_vec && (hits_q < 4'(MAX_HITS))) begin
      hits_d = hits_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (vs_neg && play && !frozen_q) begin
          state_d = S_MOVE;
          idx_d   = '0;
        end
      end

      S_MOVE: begin
        overrun_d = vs_neg;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if ((idx_q == SW'(i)) && act_d[i] && !frozen_q) begin
            y_new  = 12'(y_q[i]) + 12'(BULLET_SPEED);
            y_d[i] = y_new[CW-1:0];
            if ((y_new + 12'(BULLET_HALF_H)) > 12'(SCREEN_H - 1)) begin
              act_d[i] = 1'b0;
            end
`ifdef ENEMY_AIMED_FIRE_EN
            x_new = $signed({2'b00, x_q[i]});
            if (dir_q[i] == 2'b01) begin
              x_new = x_new + 13'sd2;
            end else if (dir_q[i] == 2'b11) begin
              x_new = x_new - 13'sd2;
            end
            if (x_new < 13'sd0) begin
              x_d[i] = '0;
            end else if (x_new > 13'sd1023) begin
              x_d[i] = 11'd1023;
            end else begin
              x_d[i] = 11'(x_new);
            end
`endif
          end
        end
        if (idx_q == SW'(NUM_SLOTS - 1)) begin
          state_d = S_FIRE;
        end else begin
          idx_d = idx_q + SW'(1);
        end
      end

      S_FIRE: begin
        overrun_d = vs_neg;
        if (!frozen_q) begin
          if (cool_q != 8'd0) begin
            cool_d = cool_q - 8'd1;
          end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (!spawned && !act_d[i]) begin
                spawned  = 1'b1;
                act_d[i] = 1'b1;
                x_d[i]   = enemy_x;
                y_d[i]   = 11'(enemy_y + 11'(PLANE_HALF_H + BULLET_HALF_H));
`ifdef ENEMY_AIMED_FIRE_EN
                aim_diff = $signed({2'b00, my_plane_x}) - $signed({2'b00, enemy_x});
                if (aim_diff > 13'sd7) begin
                  dir_d[i] = 2'b01;
                end else if (aim_diff < -13'sd7) begin
                  dir_d[i] = 2'b11;
                end else begin
                  dir_d[i] = 2'b00;
                end
`endif
              end
            end
            // With the pool full the cooldown stays at zero so the next frame retries
            if (spawned) begin
              cool_d = 8'(FIRE_PERIOD);
            end
          end
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    frozen_d = (hits_d == 4'(MAX_HITS));
    busy_d   = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cool_q    <= 8'(FIRE_PERIOD);
      act_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      hits_q    <= '0;
      frozen_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef ENEMY_AIMED_FIRE_EN
      dir_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cool_q    <= cool_d;
      act_q     <= act_d;
      x_q       <= x_d;
      y_q       <= y_d;
      hits_q    <= hits_d;
      frozen_q  <= frozen_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
`ifdef ENEMY_AIMED_FIRE_EN
      dir_q     <= dir_d;
`endif
    end
  end

  assign slot_active = act_q;
  assign bullet_x    = x_q;
  assign bullet_y    = y_q;
  assign hits        = hits_q;
  assign frozen      = frozen_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Self-checking bench for enemy_fire_scheduler: directed vector table, hand
// sequences for multi-cycle corners, and randomized traffic against a
// frame-level reference model.
module tb_enemy_fire_scheduler;

  localparam int NS  = 4;
  localparam int FP  = 1;
  localparam int SPD = 6;
  localparam int SH  = 768;
  localparam int PH  = 64;
  localparam int BH  = 16;
  localparam int MH  = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vs_neg;
  logic         play;
  logic [10:0]  enemy_x;
  logic [10:0]  enemy_y;
`ifdef ENEMY_AIMED_FIRE_EN
  logic [10:0]  my_plane_x;
`endif
  logic         hit_valid;
  logic [1:0]   hit_slot;
  logic [NS-1:0]    slot_active;
  logic [11*NS-1:0] bullet_x;
  logic [11*NS-1:0] bullet_y;
  logic [3:0]   hits;
  logic         frozen;
  logic         busy;
  logic         overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  enemy_fire_scheduler #(
    .NUM_SLOTS(NS), .FIRE_PERIOD(FP), .BULLET_SPEED(SPD), .SCREEN_H(SH),
    .PLANE_HALF_H(PH), .BULLET_HALF_H(BH), .MAX_HITS(MH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vs_neg(vs_neg), .play(play),
    .enemy_x(enemy_x), .enemy_y(enemy_y),
`ifdef ENEMY_AIMED_FIRE_EN
    .my_plane_x(my_plane_x),
`endif
    .hit_valid(hit_valid), .hit_slot(hit_slot),
    .slot_active(slot_active), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .hits(hits), .frozen(frozen), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  function automatic int ys(input int i);
    return int'(bullet_y[11*i +: 11]);
  endfunction

  function automatic int xs(input int i);
    return int'(bullet_x[11*i +: 11]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vs_neg = 1'b0;
    hit_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Pulse vs_neg and wait (bounded) for the pass to finish
  task automatic frame();
    int k;
    vs_neg = 1'b1;
    step();
    vs_neg = 1'b0;
    k = 0;
    while (busy && k < 20) begin
      step();
      k++;
    end
    chk("frame_done_busy", busy, 0);
  endtask

  task automatic hit(input int s);
    hit_valid = 1'b1;
    hit_slot  = 2'(s);
    step();
    hit_valid = 1'b0;
  endtask

  // ---------------- frame-level reference model ----------------
  bit m_act[NS];
  int m_x[NS];
  int m_y[NS];
  int m_cd, m_hits, m_cnt;
  bit m_frz;
  bit m_ovr;

  task automatic m_reset();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_cd = FP; m_hits = 0; m_cnt = 0; m_frz = 0; m_ovr = 0;
  endtask

  // Whole-frame effect: every live bullet falls, then one spawn attempt
  task automatic m_frame();
    bit done;
    if (m_frz) return;
    for (int i = 0; i < NS; i++) begin
      if (m_act[i]) begin
        m_y[i] = m_y[i] + SPD;
        if (m_y[i] + BH > SH - 1) m_act[i] = 0;
      end
    end
    if (m_cd > 0) begin
      m_cd--;
    end else begin
      done = 0;
      for (int i = 0; i < NS; i++) begin
        if (!done && !m_act[i]) begin
          done = 1;
          m_act[i] = 1;
          m_x[i] = int'(enemy_x);
          m_y[i] = (int'(enemy_y) + PH + BH) % 2048;
          m_cd = FP;
        end
      end
    end
  endtask

  // Advance model by one clock edge using the currently driven inputs
  task automatic m_edge();
    bit frz0;
    frz0 = m_frz;
    if (hit_valid && play && !frz0 && m_act[hit_slot]) begin
      m_act[hit_slot] = 0;
      if (m_hits < MH) m_hits++;
      m_frz = (m_hits == MH);
    end
    m_ovr = vs_neg && (m_cnt > 0);
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_frame();
    end else if (vs_neg && play && !frz0) begin
      m_cnt = NS + 1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         is_hit;
    int         slot;
    logic [3:0] exp_act;
    int         exp_x0;
    int         exp_y0;
    int         exp_y1;
    int         exp_hits;
    bit         exp_frz;
  } vec_t;

  vec_t tv[14];
  logic [3:0] act_now;

  initial begin
    rst_n = 1'b0; vs_neg = 1'b0; play = 1'b1; hit_valid = 1'b0; hit_slot = '0;
    enemy_x = 11'd300; enemy_y = 11'd100;
`ifdef ENEMY_AIMED_FIRE_EN
    my_plane_x = 11'd300;
`endif

    //          hit slot act      x0   y0   y1  hits frz
    tv[0]  = '{0, 0, 4'b0000,   0,   0,   0, 0, 0};
    tv[1]  = '{0, 0, 4'b0001, 300, 180,   0, 0, 0};
    tv[2]  = '{0, 0, 4'b0001, 300, 186,   0, 0, 0};
    tv[3]  = '{0, 0, 4'b0011, 300, 192, 180, 0, 0};
    tv[4]  = '{1, 3, 4'b0011, 300, 192, 180, 0, 0};
    tv[5]  = '{1, 1, 4'b0001, 300, 192, 180, 1, 0};
    tv[6]  = '{0, 0, 4'b0001, 300, 198, 180, 1, 0};
    tv[7]  = '{0, 0, 4'b0011, 300, 204, 180, 1, 0};
    tv[8]  = '{1, 0, 4'b0010, 300, 204, 180, 2, 0};
    tv[9]  = '{0, 0, 4'b0010, 300, 204, 186, 2, 0};
    tv[10] = '{0, 0, 4'b0011, 300, 180, 192, 2, 0};
    tv[11] = '{1, 0, 4'b0010, 300, 180, 192, 3, 1};
    tv[12] = '{1, 1, 4'b0010, 300, 180, 192, 3, 1};
    tv[13] = '{0, 0, 4'b0010, 300, 180, 192, 3, 1};

    // Reset state
    #3;
    chk("rst_active", slot_active, 0);
    chk("rst_bx", bullet_x, 0);
    chk("rst_by", bullet_y, 0);
    chk("rst_hits", hits, 0);
    chk("rst_frozen", frozen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    step();
    rst_n = 1'b1;

    // Spawn / move / hit / freeze table
    for (int r = 0; r < 14; r++) begin
      if (tv[r].is_hit) hit(tv[r].slot);
      else frame();
      chk($sformatf("tv%0d_active", r), slot_active, tv[r].exp_act);
      chk($sformatf("tv%0d_x0", r), xs(0), tv[r].exp_x0);
      chk($sformatf("tv%0d_y0", r), ys(0), tv[r].exp_y0);
      chk($sformatf("tv%0d_y1", r), ys(1), tv[r].exp_y1);
      chk($sformatf("tv%0d_hits", r), hits, tv[r].exp_hits);
      chk($sformatf("tv%0d_frozen", r), frozen, tv[r].exp_frz);
    end

    // Reset in the middle of a MOVE pass
    do_reset();
    frame();
    frame();
    chk("t1_pre_active", slot_active, 1);
    vs_neg = 1'b1; step(); vs_neg = 1'b0; step();
    chk("t1_busy_mid", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t1_active", slot_active, 0);
    chk("t1_by", bullet_y, 0);
    chk("t1_bx", bullet_x, 0);
    chk("t1_busy", busy, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t1_idle", busy, 0);
    frame();
    chk("t1_cooldown_reloaded", slot_active, 0);
    frame();
    chk("t1_spawn_after", slot_active, 1);

    // Off-screen retirement and pool-full retry
    do_reset();
    enemy_x = 11'd10; enemy_y = 11'd606;
    for (int f = 0; f < 12; f++) frame();
    chk("t3_y0_746", ys(0), 746);
    chk("t3_pool_full", slot_active, 4'b1111);
    vs_neg = 1'b1; step(); vs_neg = 1'b0; step();
    chk("t3_y0_752", ys(0), 752);
    chk("t3_retired", slot_active[0], 0);
    begin
      int k;
      k = 0;
      while (busy && k < 20) begin step(); k++; end
    end
    chk("t3_done", busy, 0);
    chk("t3_respawn_active", slot_active, 4'b1111);
    chk("t3_respawn_y0", ys(0), 686);
    chk("t3_respawn_x0", xs(0), 10);
    chk("t3_y1", ys(1), 740);

    // Hit colliding with MOVE on the same slot, and overrun
    vs_neg = 1'b1; step(); vs_neg = 1'b0;
    step();
    step();
    hit_valid = 1'b1; hit_slot = 2'd2;
    step();
    hit_valid = 1'b0;
    chk("t6_slot2_cleared", slot_active[2], 0);
    chk("t6_slot2_y", ys(2), 728);
    chk("t6_hits", hits, 1);
    chk("t6_overrun_idle", overrun, 0);
    vs_neg = 1'b1; step(); vs_neg = 1'b0;
    chk("t6_overrun", overrun, 1);
    chk("t6_busy", busy, 1);
    step();
    chk("t6_overrun_end", overrun, 0);
    chk("t6_busy_end", busy, 0);
    chk("t6_active", slot_active, 4'b1011);
    chk("t6_y3", ys(3), 722);

    // Randomized traffic against the frame-level model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 400 == 0) begin
        play = 1'b1;
        do_reset();
        m_reset();
      end
      vs_neg    = ($urandom % 6 == 0);
      if (cyc % 37 == 0) play = ($urandom % 5 != 0);
      hit_valid = (m_cnt == 0) && ($urandom % 30 == 0);
      hit_slot  = 2'($urandom % 4);
      enemy_x   = 11'($urandom % 2048);
      enemy_y   = 11'($urandom % 701);
      m_edge();
      step();
      hit_valid = 1'b0;
      chk("rnd_busy", busy, (m_cnt > 0));
      chk("rnd_overrun", overrun, m_ovr);
      if (m_cnt == 0) begin
        for (int i = 0; i < NS; i++) act_now[i] = m_act[i];
        chk("rnd_active", slot_active, act_now);
        chk("rnd_hits", hits, m_hits);
        chk("rnd_frozen", frozen, m_frz);
        for (int i = 0; i < NS; i++) begin
          chk($sformatf("rnd_x%0d", i), xs(i), m_x[i]);
          chk($sformatf("rnd_y%0d", i), ys(i), m_y[i]);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
